// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU op encodings (common with the ALU)
// and the arbiter FSM state type.
package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU-side and response channels of the ALU arbiter.
// slave = arbiter side; master = requesters plus the parent-owned ALU.
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
);
  logic [NUM_REQ-1:0]      req_valid_i;
  logic [NUM_REQ-1:0]      req_ready_o;
  logic [NUM_REQ*XLEN-1:0] req_data_1_i;
  logic [NUM_REQ*XLEN-1:0] req_data_2_i;
  logic [NUM_REQ*4-1:0]    req_op_i;
  logic [XLEN-1:0]         alu_data_1_o;
  logic [XLEN-1:0]         alu_data_2_o;
  alu_op_t                 alu_op_o;
  logic [XLEN-1:0]         alu_result_i;
  logic                    alu_zero_i;
  logic [NUM_REQ-1:0]      rsp_valid_o;
  logic [NUM_REQ-1:0]      rsp_ready_i;
  logic [XLEN-1:0]         rsp_result_o;
  logic                    rsp_zero_o;

  modport slave (
    input  req_valid_i, req_data_1_i, req_data_2_i, req_op_i,
    input  alu_result_i, alu_zero_i, rsp_ready_i,
    output req_ready_o, alu_data_1_o, alu_data_2_o, alu_op_o,
    output rsp_valid_o, rsp_result_o, rsp_zero_o
  );

  modport master (
    output req_valid_i, req_data_1_i, req_data_2_i, req_op_i,
    output alu_result_i, alu_zero_i, rsp_ready_i,
    input  req_ready_o, alu_data_1_o, alu_data_2_o, alu_op_o,
    input  rsp_valid_o, rsp_result_o, rsp_zero_o
  );
endinterface

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin pick: first requester at or above i_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx,
  output logic               o_any
);
  always_comb begin
    int j;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[j]) begin
        o_grant[j] = 1'b1;
        o_idx      = IDW'(j);
        o_any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters:
// round-robin accept, registered operands, captured result returned per requester.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input logic         clk_i,
  input logic         rst_ni,
  alu_arbiter_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t     r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_owner;
  logic [XLEN-1:0] r_data_1;
  logic [XLEN-1:0] r_data_2;
  alu_op_t        r_op;
  logic [XLEN-1:0] r_result;
  logic           r_zero;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_idx;
  logic               w_any;
  logic               w_accept;
  logic               w_rsp_done;
  logic [NUM_REQ-1:0] w_rsp_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
    .i_req   (bus.req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_accept   = (r_state == IDLE) && w_any;
  assign w_rsp_done = (r_state == RESP) && bus.rsp_ready_i[r_owner];

  // Ready is gated by rst_ni so nothing is offered while reset is held.
  assign bus.req_ready_o = (rst_ni && (r_state == IDLE)) ? w_grant : '0;

  always_comb begin
    w_rsp_valid = '0;
    if (r_state == RESP) w_rsp_valid[r_owner] = 1'b1;
  end

  assign bus.rsp_valid_o  = w_rsp_valid;
  assign bus.rsp_result_o = r_result;
  assign bus.rsp_zero_o   = r_zero;
  assign bus.alu_data_1_o = r_data_1;
  assign bus.alu_data_2_o = r_data_2;
  assign bus.alu_op_o     = r_op;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_data_1 <= '0;
      r_data_2 <= '0;
      r_op     <= ALU_ADD;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_data_1 <= bus.req_data_1_i[w_idx*XLEN +: XLEN];
          r_data_2 <= bus.req_data_2_i[w_idx*XLEN +: XLEN];
          r_op     <= alu_op_t'(bus.req_op_i[w_idx*4 +: 4]);
          r_owner  <= w_idx;
          r_rr_ptr <= (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
          r_state  <= EXEC;
        end
        // ALU has settled on the registered operands by the end of EXEC.
        EXEC: begin
          r_result <= bus.alu_result_i;
          r_zero   <= bus.alu_zero_i;
          r_state  <= RESP;
        end
        RESP: if (w_rsp_done) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU as the parent, table of request vectors
// plus hand sequences for latency, fairness, backpressure, ownership and reset.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  alu_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) bus ();

  alu_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // Reference ALU owned by the parent
  always_comb begin
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [XLEN-1:0] res;
    sa  = $signed(bus.alu_data_1_o);
    sb  = $signed(bus.alu_data_2_o);
    res = '0;
    case (bus.alu_op_o)
      ALU_ADD:  res = bus.alu_data_1_o + bus.alu_data_2_o;
      ALU_SUB:  res = bus.alu_data_1_o - bus.alu_data_2_o;
      ALU_AND:  res = bus.alu_data_1_o & bus.alu_data_2_o;
      ALU_OR:   res = bus.alu_data_1_o | bus.alu_data_2_o;
      ALU_XOR:  res = bus.alu_data_1_o ^ bus.alu_data_2_o;
      ALU_SLL:  res = bus.alu_data_1_o << bus.alu_data_2_o[4:0];
      ALU_SRL:  res = bus.alu_data_1_o >> bus.alu_data_2_o[4:0];
      ALU_SRA:  res = sa >>> bus.alu_data_2_o[4:0];
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, (sa < sb)};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, (bus.alu_data_1_o < bus.alu_data_2_o)};
      default:  res = '0;
    endcase
    bus.alu_result_i = res;
    bus.alu_zero_i   = (res == '0);
  end

  typedef struct {
    int        owner;
    logic [31:0] res;
    logic        zero;
  } sb_t;

  typedef struct {
    logic [1:0]  mask;
    logic [3:0]  op0; logic [31:0] a0; logic [31:0] b0; logic [31:0] r0; logic z0;
    logic [3:0]  op1; logic [31:0] a1; logic [31:0] b1; logic [31:0] r1; logic z1;
    int          first;
  } vec_t;

  sb_t         sb_q[$];
  int          grant_log[$];
  logic [31:0] exp_res  [NUM_REQ];
  logic        exp_zero [NUM_REQ];
  int          errors = 0;
  int          checks = 0;
  vec_t        tbl[8];

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on response handshake
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      sb_q.delete();
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (bus.req_valid_i[r] && bus.req_ready_o[r]) begin
          sb_t e;
          e.owner = r; e.res = exp_res[r]; e.zero = exp_zero[r];
          sb_q.push_back(e);
          grant_log.push_back(r);
        end
      end
      if (|(bus.rsp_valid_o & bus.rsp_ready_i)) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_rsp: got rsp_valid %0h, required none", bus.rsp_valid_o);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("rsp_owner",  64'(bus.rsp_valid_o), 64'(1 << e.owner));
          check("rsp_result", 64'(bus.rsp_result_o), 64'(e.res));
          check("rsp_zero",   64'(bus.rsp_zero_o),  64'(e.zero));
        end
      end
    end
  end

  task automatic set_req(int r, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] er, logic ez);
    bus.req_op_i[r*4 +: 4]        = op;
    bus.req_data_1_i[r*XLEN +: XLEN] = a;
    bus.req_data_2_i[r*XLEN +: XLEN] = b;
    exp_res[r]  = er;
    exp_zero[r] = ez;
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  // Raise valid on mask; drop each valid right after its accept edge.
  task automatic serve(logic [NUM_REQ-1:0] mask, output int first);
    logic [NUM_REQ-1:0] pend;
    int n;
    pend  = mask;
    n     = 0;
    first = -1;
    bus.req_valid_i = mask;
    while (pend != '0 && n < 40) begin
      @(negedge clk_i);
      for (int r = 0; r < NUM_REQ; r++)
        if (pend[r] && bus.req_ready_o[r]) begin
          pend[r] = 1'b0;
          if (first < 0) first = r;
        end
      step();
      bus.req_valid_i = pend;
      n++;
    end
    if (pend != '0) begin
      checks++; errors++;
      $display("FAIL serve_timeout: pending %0h, required 0", pend);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bus.rsp_valid_o != '0) && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    step();
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: outstanding %0d, required 0", sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int n;

    tbl[0] = '{2'b11, ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b1,
               ALU_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0, 0};
    tbl[1] = '{2'b01, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0,
               ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b1, 0};
    tbl[2] = '{2'b11, ALU_AND, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0,
               ALU_XOR, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1};
    tbl[3] = '{2'b10, ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b1,
               ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1};
    tbl[4] = '{2'b11, ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1,
               ALU_SRA, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 0};
    tbl[5] = '{2'b01, 4'hF, 32'd3, 32'd4, 32'd0, 1'b1,
               ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b1, 0};
    tbl[6] = '{2'b11, ALU_SRL, 32'h80000000, 32'd31, 32'd1, 1'b0,
               ALU_SUB, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1};
    tbl[7] = '{2'b10, ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b1,
               ALU_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1};

    bus.req_valid_i  = '1;
    bus.req_data_1_i = '0;
    bus.req_data_2_i = '0;
    bus.req_op_i     = '0;
    bus.rsp_ready_i  = '1;
    #2;
    check("rst_req_ready",  64'(bus.req_ready_o),  64'd0);
    check("rst_rsp_valid",  64'(bus.rsp_valid_o),  64'd0);
    check("rst_alu_op",     64'(bus.alu_op_o),     64'(ALU_ADD));
    check("rst_alu_data_1", 64'(bus.alu_data_1_o), 64'd0);
    check("rst_alu_data_2", 64'(bus.alu_data_2_o), 64'd0);
    check("rst_rsp_result", 64'(bus.rsp_result_o), 64'd0);
    check("rst_rsp_zero",   64'(bus.rsp_zero_o),   64'd0);
    bus.req_valid_i = '0;
    step(); step();
    rst_ni = 1'b1;
    step();

    for (int v = 0; v < 8; v++) begin
      set_req(0, tbl[v].op0, tbl[v].a0, tbl[v].b0, tbl[v].r0, tbl[v].z0);
      set_req(1, tbl[v].op1, tbl[v].a1, tbl[v].b1, tbl[v].r1, tbl[v].z1);
      serve(tbl[v].mask, first);
      check($sformatf("vec%0d_first_grant", v), 64'(first), 64'(tbl[v].first));
      drain();
    end

    // Fairness: both valid continuously for six ops
    set_req(0, ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0);
    set_req(1, ALU_ADD, 32'd2, 32'd2, 32'd4, 1'b0);
    grant_log.delete();
    bus.req_valid_i = 2'b11;
    n = 0;
    while (grant_log.size() < 6 && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    step();
    bus.req_valid_i = '0;
    drain();
    check("fair_count", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check($sformatf("fair_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));

    // Latency: ready same cycle, response after the next edge
    set_req(0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
    bus.req_valid_i = 2'b01;
    @(negedge clk_i);
    check("lat_req_ready", 64'(bus.req_ready_o), 64'b01);
    step();
    bus.req_valid_i = '0;
    @(negedge clk_i);
    check("lat_exec_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    @(negedge clk_i);
    check("lat_rsp_valid",  64'(bus.rsp_valid_o),  64'b01);
    check("lat_rsp_result", 64'(bus.rsp_result_o), 64'd12);
    drain();

    // Backpressure on SLL with requester 1 waiting
    bus.rsp_ready_i = '0;
    set_req(0, ALU_SLL, 32'd1, 32'd4, 32'd16, 1'b0);
    set_req(1, ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0);
    serve(2'b01, first);
    bus.req_valid_i = 2'b10;
    @(negedge clk_i);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check($sformatf("bp_rsp_valid%0d", c),  64'(bus.rsp_valid_o),  64'b01);
      check($sformatf("bp_rsp_result%0d", c), 64'(bus.rsp_result_o), 64'd16);
      check($sformatf("bp_req_ready%0d", c),  64'(bus.req_ready_o),  64'd0);
    end
    step();
    bus.rsp_ready_i = '1;
    serve(2'b10, first);
    check("bp_second_grant", 64'(first), 64'd1);
    drain();

    // Non-owner ready is ignored
    bus.rsp_ready_i = 2'b10;
    set_req(0, ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0);
    set_req(1, ALU_XOR, 32'h5, 32'h5, 32'd0, 1'b1);
    serve(2'b01, first);
    bus.req_valid_i = 2'b10;
    @(negedge clk_i);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check($sformatf("wo_rsp_valid%0d", c),  64'(bus.rsp_valid_o),  64'b01);
      check($sformatf("wo_rsp_result%0d", c), 64'(bus.rsp_result_o), 64'd5);
    end
    step();
    bus.rsp_ready_i = 2'b01;
    @(negedge clk_i);
    step();
    bus.rsp_ready_i = 2'b11;
    @(negedge clk_i);
    check("wo_idle_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("wo_idle_req_ready", 64'(bus.req_ready_o), 64'b10);
    step();
    bus.req_valid_i = '0;
    drain();

    // Reset while the op is in EXEC
    set_req(0, ALU_SRA, 32'h80000000, 32'd4, 32'hF8000000, 1'b0);
    set_req(1, ALU_OR, 32'h1, 32'h2, 32'h3, 1'b0);
    serve(2'b01, first);
    rst_ni = 1'b0;
    bus.req_valid_i = 2'b11;
    #1;
    check("rstx_rsp_valid", 64'(bus.rsp_valid_o),  64'd0);
    check("rstx_alu_op",    64'(bus.alu_op_o),     64'(ALU_ADD));
    check("rstx_alu_data",  64'(bus.alu_data_1_o), 64'd0);
    check("rstx_req_ready", 64'(bus.req_ready_o),  64'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      check($sformatf("rstx_hold_rsp_valid%0d", c), 64'(bus.rsp_valid_o), 64'd0);
    end
    step();
    rst_ni = 1'b1;
    serve(2'b11, first);
    check("rstx_rr_ptr_first", 64'(first), 64'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
